// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and reusable by the receiver:
// FSM state encoding, parity-type and line-level constants, and the parity
// helper function used by uart_parity_calc.
package uart_pkg;

  // Widest data word any UART block in this family supports.
  localparam int MAX_DATA_WIDTH = 9;

  // Frame-sequencing states. STOP2 is only reachable when the second stop bit
  // is compiled in (UART_TX_STOP2_EN).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } uart_state_e;

  // Parity selection as carried on PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Mark level: the line rests here between frames and during stop bits.
  localparam logic UART_IDLE = 1'b1;

  // Parity over a zero-extended word. Zero padding does not change the XOR,
  // so callers with narrower words simply extend to MAX_DATA_WIDTH.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] word,
                                      input logic                      par_typ);
    logic even_s;
    even_s = ^word;
    if (par_typ == PAR_ODD) begin
      return ~even_s;
    end else begin
      return even_s;
    end
  endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_if.sv
// Request/serial-line bundle between the register-file/FIFO side (master)
// and the UART transmitter (slave).
interface uart_tx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  // Upstream side: presents words and watches busy before the next request.
  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  // Transmitter side: consumes requests, drives the line and busy.
  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );

endinterface : uart_tx_if

// File: rtl/uart_parity_calc.sv
// Combinational parity generator: XOR-reduce of the data word, inverted for
// odd parity. Kept as its own block so the receiver can reuse it for checking.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  logic [MAX_DATA_WIDTH-1:0] word_ext_s;

  // Zero-extend the word to the helper's fixed width and evaluate parity.
  always_comb begin
    word_ext_s                 = '0;
    word_ext_s[DATA_WIDTH-1:0] = data;
    parity                     = parity_bit(word_ext_s, par_typ);
  end

endmodule : uart_parity_calc

// File: rtl/uart_tx.sv
// UART transmitter. One CLK period is one bit period. A single-cycle
// Data_Valid in IDLE latches the word and parity settings and starts a frame:
// start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Requests arriving while busy are dropped.
//
// Build option: define UART_TX_STOP2_EN to append a second stop bit (STOP2
// state); without it the frame has a single stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic      CLK,
  input logic      RST,
  uart_tx_if.slave bus
);

  // Counter is sized to index the last data bit; a 1-bit word still needs
  // one counter bit.
  localparam int                CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  uart_state_e           state_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r;
  logic                  par_typ_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  tx_out_r;
  logic                  busy_r;

  logic                  parity_s;
  logic [CNT_W-1:0]      cnt_next_s;

  // Parity is derived from the latched word and type, so upstream changes
  // after accept cannot disturb the frame in flight.
  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (data_r),
    .par_typ (par_typ_r),
    .parity  (parity_s)
  );

  assign cnt_next_s = cnt_r + CNT_ONE;

  // Frame sequencer: every edge drives the bit for the following period, so
  // the line value and busy are both registered and change only on CLK.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= PAR_EVEN;
      cnt_r     <= '0;
      tx_out_r  <= UART_IDLE;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.Data_Valid) begin
            data_r    <= bus.P_DATA;
            par_en_r  <= bus.PAR_EN;
            par_typ_r <= bus.PAR_TYP;
            tx_out_r  <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= START;
          end else begin
            tx_out_r  <= UART_IDLE;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end
        end

        START: begin
          // Start bit is on the line; queue data bit 0 and arm the counter.
          tx_out_r <= data_r[0];
          cnt_r    <= '0;
          state_r  <= DATA;
        end

        DATA: begin
          if (cnt_r == CNT_LAST) begin
            if (par_en_r) begin
              tx_out_r <= parity_s;
              state_r  <= PARITY;
            end else begin
              tx_out_r <= UART_IDLE;
              state_r  <= STOP;
            end
          end else begin
            tx_out_r <= data_r[cnt_next_s];
            cnt_r    <= cnt_next_s;
            state_r  <= DATA;
          end
        end

        PARITY: begin
          tx_out_r <= UART_IDLE;
          state_r  <= STOP;
        end

        STOP: begin
`ifdef UART_TX_STOP2_EN
          // Second mark bit; busy covers it too.
          tx_out_r <= UART_IDLE;
          busy_r   <= 1'b1;
          state_r  <= STOP2;
`else
          tx_out_r <= UART_IDLE;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
`endif
        end

`ifdef UART_TX_STOP2_EN
        STOP2: begin
          tx_out_r <= UART_IDLE;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
`endif

        default: begin
          // Unreachable encodings recover to a quiet line.
          tx_out_r <= UART_IDLE;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.TX_OUT = tx_out_r;
  assign bus.busy   = busy_r;

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx. A negedge monitor captures every frame
// (the cycles where busy is high) and compares it with the next entry of a
// scoreboard queue filled when the request is driven. Idle cycles must show
// a mark level.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int  DW   = 8;
  localparam time HALF = 5;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #HALF CLK = ~CLK;

  typedef struct {
    logic [15:0] bits;   // bit i = i-th transmitted period
    int          len;
  } frame_t;

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic [15:0] bits;   // single-stop frame
    int          len;
  } vec_t;

  frame_t sb_q[$];
  vec_t   vecs[6];

  int tests = 0;
  int fails = 0;

  // Monitor state
  logic [15:0] cur_bits = 16'h0000;
  int          cur_len  = 0;
  bit          in_frame = 1'b0;

  // Expected frame, extended with the extra mark bit when two stop bits are built.
  function automatic frame_t mk_exp(input logic [15:0] bits, input int len);
    frame_t f;
    f.bits = bits;
    f.len  = len;
`ifdef UART_TX_STOP2_EN
    f.bits[len] = 1'b1;
    f.len       = len + 1;
`endif
    return f;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame capture and scoreboard comparison on the falling edge.
  always @(negedge CLK) begin
    if (!RST) begin
      in_frame = 1'b0;
      cur_len  = 0;
      cur_bits = 16'h0000;
    end else if (bus.busy === 1'b1) begin
      if (cur_len < 16) cur_bits[cur_len] = bus.TX_OUT;
      cur_len++;
      in_frame = 1'b1;
    end else begin
      if (in_frame) begin
        tests++;
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got bits %0h len %0d expected no frame", cur_bits, cur_len);
        end else begin
          frame_t e;
          e = sb_q.pop_front();
          if (cur_len != e.len || cur_bits !== e.bits) begin
            fails++;
            $display("FAIL frame: got bits %0h len %0d expected bits %0h len %0d",
                     cur_bits, cur_len, e.bits, e.len);
          end
        end
      end
      in_frame = 1'b0;
      cur_len  = 0;
      cur_bits = 16'h0000;
      tests++;
      if (bus.TX_OUT !== UART_IDLE) begin
        fails++;
        $display("FAIL idle_mark: got %b expected 1 at %0t", bus.TX_OUT, $time);
      end
    end
  end

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check(name, {15'd0, bus.busy}, 16'd0);
  endtask

  task automatic drive_frame(input vec_t v);
    @(negedge CLK);
    bus.P_DATA     = v.data;
    bus.PAR_EN     = v.par_en;
    bus.PAR_TYP    = v.par_typ;
    bus.Data_Valid = 1'b1;
    sb_q.push_back(mk_exp(v.bits, v.len));
    @(negedge CLK);
    check("accept_busy", {15'd0, bus.busy}, 16'd1);
    check("start_bit", {15'd0, bus.TX_OUT}, 16'd0);
    bus.Data_Valid = 1'b0;
    // Disturb the inputs mid-frame; the frame must not change.
    bus.P_DATA  = ~v.data;
    bus.PAR_EN  = ~v.par_en;
    bus.PAR_TYP = ~v.par_typ;
    wait_idle("frame_end_timeout");
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'hA5, par_en: 1'b1, par_typ: PAR_EVEN, bits: 16'h054A, len: 11};
    vecs[1] = '{data: 8'hA5, par_en: 1'b1, par_typ: PAR_ODD,  bits: 16'h074A, len: 11};
    vecs[2] = '{data: 8'h00, par_en: 1'b0, par_typ: PAR_EVEN, bits: 16'h0200, len: 10};
    vecs[3] = '{data: 8'h55, par_en: 1'b0, par_typ: PAR_ODD,  bits: 16'h02AA, len: 10};
    vecs[4] = '{data: 8'h81, par_en: 1'b0, par_typ: PAR_EVEN, bits: 16'h0302, len: 10};
    vecs[5] = '{data: 8'hFF, par_en: 1'b1, par_typ: PAR_ODD,  bits: 16'h07FE, len: 11};

    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_tx", {15'd0, bus.TX_OUT}, 16'd1);
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    RST = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_busy", {15'd0, bus.busy}, 16'd0);
    end

    // Table-driven frames
    for (int i = 0; i < 6; i++) drive_frame(vecs[i]);

    // Request while busy is dropped
    @(negedge CLK);
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    sb_q.push_back(mk_exp(16'h0278, 10));
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("ignore_bit3", {15'd0, bus.TX_OUT}, 16'd1);
    bus.P_DATA = 8'hFF; bus.PAR_EN = 1'b1; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    wait_idle("ignore_timeout");
    for (int i = 0; i < 15; i++) begin
      @(negedge CLK);
      check("ignore_no_frame", {15'd0, bus.busy}, 16'd0);
    end

    // Back-to-back with Data_Valid held high
    @(negedge CLK);
    bus.P_DATA = 8'h55; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    sb_q.push_back(mk_exp(16'h02AA, 10));
    sb_q.push_back(mk_exp(16'h0302, 10));
    @(negedge CLK);
    check("b2b_first_busy", {15'd0, bus.busy}, 16'd1);
    bus.P_DATA = 8'h81;
    wait_idle("b2b_first_timeout");
    @(negedge CLK);
    check("b2b_gap", {15'd0, bus.busy}, 16'd1);
    bus.Data_Valid = 1'b0;
    wait_idle("b2b_second_timeout");
    repeat (3) @(negedge CLK);

    // Reset during data bit 3, then a clean frame
    @(negedge CLK);
    bus.P_DATA = 8'hA5; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(negedge CLK);
    bus.Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    check("pre_rst_busy", {15'd0, bus.busy}, 16'd1);
    #1 RST = 1'b0;
    #1;
    check("midrst_tx", {15'd0, bus.TX_OUT}, 16'd1);
    check("midrst_busy", {15'd0, bus.busy}, 16'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst_busy", {15'd0, bus.busy}, 16'd0);
    drive_frame(vecs[3]);

    repeat (5) @(negedge CLK);
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_uart_tx

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter. It is the transmit-side counterpart of the RX oversampling/data-sampling path in the UART block.
- Accepts a parallel word with a single-cycle valid. Serialises it LSB-first as start, data, optional parity and stop bits on TX_OUT.
- CLK is the TX clock (one CLK period = one bit period), already divided to the baud rate by the system clock divider.
- Reports a busy flag upstream to the register-file/FIFO side.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..9).

Ports:
- CLK  input  1  TX bit clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to send; sampled only on accept.
- Data_Valid  input  1  request strobe; P_DATA/PAR_EN/PAR_TYP are valid while high.
- PAR_EN  input  1  1 = parity bit inserted after data.
- PAR_TYP  input  1  0 = even, 1 = odd; sampled on accept.
- TX_OUT  output  1  serial line; idle/mark = 1.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST low, asynchronous): state IDLE, TX_OUT = 1, busy = 0, data/parity registers = 0.
- All outputs are registered and change only on the CLK rising edge.
- FSM states:
  - IDLE -> START when Data_Valid = 1.
  - START -> DATA.
  - DATA -> DATA until the bit counter reaches DATA_WIDTH-1, then -> PARITY if the latched PAR_EN = 1, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Accept: on the edge where state = IDLE and Data_Valid = 1:
  - Latch P_DATA, PAR_EN and PAR_TYP.
  - Compute the parity bit: XOR-reduce of the latched data, inverted when PAR_TYP = 1.
  - Drive TX_OUT = 0 (start bit) and busy = 1 on that same edge.
  - Latency: Data_Valid sampled high -> start bit visible one edge later.
- Each subsequent edge drives the next bit:
  - data bit 0 .. DATA_WIDTH-1, LSB first;
  - then the parity bit, if enabled;
  - then TX_OUT = 1 for the stop bit.
- Frame length is 1 + DATA_WIDTH + PAR_EN + 1 CLK periods (10 or 11 at default).
- Bit counter: $clog2(DATA_WIDTH) bits wide, cleared on entry to DATA, incremented each DATA cycle. No wrap is used beyond DATA_WIDTH-1.
- busy falls and TX_OUT stays 1 on the edge that leaves STOP.
- Data_Valid while busy = 1 (any non-IDLE state) is ignored. The word is dropped; upstream must wait for busy = 0.
- At least one IDLE cycle is guaranteed between frames. Data_Valid held high continuously sends back-to-back frames separated by exactly one idle (mark) bit.
- Changes to P_DATA/PAR_EN/PAR_TYP during a frame do not affect that frame.
- Reset mid-frame aborts immediately: TX_OUT = 1 and busy = 0 asynchronously, and no partial bits are resumed.
- X on Data_Valid in IDLE is a verification error; the design does not need to tolerate it.

Optional Feature:
- Macro UART_TX_STOP2_EN.
- Defined: a STOP2 state follows STOP and drives a second mark bit. Frame length becomes 2 + DATA_WIDTH + PAR_EN + 1, and busy stays high through STOP2.
- Undefined: a single stop bit, exactly as above, with no STOP2 state in the netlist.

Decomposition:
- Shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, STOP2);
  - parity-type constants PAR_EVEN = 0, PAR_ODD = 1;
  - the idle-line level constant UART_IDLE = 1.
- One sub-module, uart_parity_calc: combinational XOR-reduce plus type inversion, parameterised by DATA_WIDTH. It is instantiated once and shared with future RX parity-check reuse.

Test Plan:
- Reset idle: RST low, then high with Data_Valid = 0 for 20 cycles -> TX_OUT = 1 and busy = 0 throughout.
- Even parity: P_DATA = 0xA5, PAR_EN = 1, PAR_TYP = 0, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1; busy high exactly 11 cycles.
- Odd parity, no parity: 0xA5 with PAR_TYP = 1 -> parity bit 1. 0x00 with PAR_EN = 0 -> 0,0,0,0,0,0,0,0,0,1; busy high 10 cycles.
- Ignore while busy: send 0x3C, pulse Data_Valid with 0xFF at the 4th data bit -> the 0x3C frame completes unchanged, no second frame, busy = 0 afterward.
- Back-to-back: Data_Valid held high with 0x55 then 0x81, PAR_EN = 0 -> two 10-bit frames with exactly one idle-1 cycle between them.
- Reset mid-frame and option: assert RST during data bit 3 -> TX_OUT = 1 and busy = 0 immediately, and the next request sends a full clean frame. With UART_TX_STOP2_EN, the 0xA5 even-parity frame ends in two 1s and busy lasts 12 cycles.
